// File: rtl/multi_interval_monitor.sv
// NUM_MON independent tag-interval monitors on a sorted multi-lane tag stream, with a
// wishbone register file for configuration, violation counts and first-failure capture.

module multi_interval_monitor_chan #(
  parameter int WORD_WIDTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        act,
  input  logic [5:0]                  ch,
  input  logic [63:0]                 lower,
  input  logic [63:0]                 upper,
  input  logic                        tvalid,
  input  logic [WORD_WIDTH-1:0]       tkeep,
  input  logic [WORD_WIDTH-1:0][5:0]  lane_ch,
  input  logic [WORD_WIDTH-1:0][63:0] t_s1,
  input  logic [WORD_WIDTH-1:0][63:0] t_s2,
  output logic [CNT_WIDTH-1:0]        count,
  output logic [63:0]                 first_fail
);
  localparam int PW = $clog2(WORD_WIDTH + 1);
  localparam int SW = CNT_WIDTH + PW;
  localparam logic [SW-1:0] CMAX = {{PW{1'b0}}, {CNT_WIDTH{1'b1}}};

  logic [WORD_WIDTH-1:0]        q1_d, q1_q, q2_d, q2_q, pv2_d, pv2_q;
  logic [WORD_WIDTH-1:0]        dv3_d, dv3_q, err4_d, err4_q;
  logic [WORD_WIDTH-1:0][63:0]  prev2_d, prev2_q, diff3_d, diff3_q;
  logic [WORD_WIDTH-1:0][62:0]  diff4_d, diff4_q;
  logic [63:0]                  prev_d, prev_q, ff_d, ff_q;
  logic                         prev_vld_d, prev_vld_q;
  logic [CNT_WIDTH-1:0]         count_d, count_q;
  logic [63:0]                  run_t;
  logic                         run_v;
  logic [PW-1:0]                pop;
  logic [SW-1:0]                sum;

  always_comb begin
    // S1: qualify
    for (int i = 0; i < WORD_WIDTH; i++)
      q1_d[i] = !clr && act && tvalid && tkeep[i] && (lane_ch[i] == ch);
    // S2: each lane takes the nearest lower qualifying lane, else the stored prev
    run_t = prev_q;
    run_v = prev_vld_q;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      prev2_d[i] = run_t;
      pv2_d[i]   = run_v;
      if (q1_q[i]) begin
        run_t = t_s1[i];
        run_v = 1'b1;
      end
    end
    prev_d     = run_t;
    prev_vld_d = (clr || !act) ? 1'b0 : run_v;
    q2_d       = clr ? '0 : q1_q;
    // S3: interval
    dv3_d = clr ? '0 : (q2_q & pv2_q);
    for (int i = 0; i < WORD_WIDTH; i++)
      diff3_d[i] = t_s2[i] - prev2_q[i];
    // S4: window check, bounds inclusive
    for (int i = 0; i < WORD_WIDTH; i++) begin
      err4_d[i]  = !clr && dv3_q[i] && ((diff3_q[i] < lower) || (diff3_q[i] > upper));
      diff4_d[i] = diff3_q[i][62:0];
    end
    // S5: saturating count and sticky first failure
    pop = '0;
    for (int i = 0; i < WORD_WIDTH; i++)
      pop = pop + PW'(err4_q[i]);
    sum     = SW'(count_q) + SW'(pop);
    count_d = (sum > CMAX) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    ff_d    = ff_q;
    if (!ff_q[63])
      for (int i = WORD_WIDTH - 1; i >= 0; i--)
        if (err4_q[i]) ff_d = {1'b1, diff4_q[i]};
    if (clr) begin
      count_d = '0;
      ff_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q1_q       <= '0;
      q2_q       <= '0;
      pv2_q      <= '0;
      dv3_q      <= '0;
      err4_q     <= '0;
      prev2_q    <= '0;
      diff3_q    <= '0;
      diff4_q    <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      count_q    <= '0;
      ff_q       <= '0;
    end else begin
      q1_q       <= q1_d;
      q2_q       <= q2_d;
      pv2_q      <= pv2_d;
      dv3_q      <= dv3_d;
      err4_q     <= err4_d;
      prev2_q    <= prev2_d;
      diff3_q    <= diff3_d;
      diff4_q    <= diff4_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      count_q    <= count_d;
      ff_q       <= ff_d;
    end
  end

  assign count      = count_q;
  assign first_fail = ff_q;
endmodule

module multi_interval_monitor #(
  parameter int WORD_WIDTH = 4,
  parameter int NUM_MON    = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [WORD_WIDTH-1:0]    s_axis_tkeep,
  input  logic [6*WORD_WIDTH-1:0]  s_axis_channel,
  input  logic [64*WORD_WIDTH-1:0] s_axis_tagtime,
  input  logic                     wb_cyc,
  input  logic                     wb_stb,
  input  logic                     wb_we,
  input  logic [15:0]              wb_adr,
  input  logic [31:0]              wb_dat_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack,
  output logic                     fail_any
);
  logic [WORD_WIDTH-1:0][5:0]  lane_ch;
  logic [WORD_WIDTH-1:0][63:0] lane_t, t_s1_d, t_s1_q, t_s2_d, t_s2_q;
  logic [NUM_MON-1:0][5:0]     cfg_ch_d, cfg_ch_q;
  logic [NUM_MON-1:0]          cfg_en_d, cfg_en_q, ff_vld;
  logic [NUM_MON-1:0][63:0]    lower_d, lower_q, upper_d, upper_q, ff_w;
  logic [NUM_MON-1:0][CNT_WIDTH-1:0] count_w;
  logic        gen_d, gen_q, clr_d, clr_q, ack_d, ack_q, fail_d, fail_q, wr;
  logic [31:0] dat_d, dat_q, rd;
  logic [9:0]  mon_blk;

  assign lane_ch       = s_axis_channel;
  assign lane_t        = s_axis_tagtime;
  assign s_axis_tready = 1'b1;
  assign mon_blk       = wb_adr[15:6];

  for (genvar m = 0; m < NUM_MON; m++) begin : g_mon
    multi_interval_monitor_chan #(.WORD_WIDTH(WORD_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_mon (
      .clk(clk), .rst(rst), .clr(clr_q), .act(gen_q && cfg_en_q[m]),
      .ch(cfg_ch_q[m]), .lower(lower_q[m]), .upper(upper_q[m]),
      .tvalid(s_axis_tvalid), .tkeep(s_axis_tkeep), .lane_ch(lane_ch),
      .t_s1(t_s1_q), .t_s2(t_s2_q), .count(count_w[m]), .first_fail(ff_w[m])
    );
    assign ff_vld[m] = ff_w[m][63];
  end

  always_comb begin
    t_s1_d   = lane_t;
    t_s2_d   = t_s1_q;
    cfg_ch_d = cfg_ch_q;
    cfg_en_d = cfg_en_q;
    lower_d  = lower_q;
    upper_d  = upper_q;
    gen_d    = gen_q;
    clr_d    = 1'b0;
    // one ack per request even if the master holds stb through the ack cycle
    ack_d    = wb_cyc && wb_stb && !ack_q;
    wr       = ack_d && wb_we;
    rd       = '0;
    if (wb_adr == 16'h0000) rd = 32'(NUM_MON);
    else if (wb_adr == 16'h0004) begin
      rd = {30'b0, gen_q, 1'b0};
      if (wr) begin
        clr_d = wb_dat_i[0];
        gen_d = wb_dat_i[1];
      end
    end else begin
      for (int m = 0; m < NUM_MON; m++) begin
        if (mon_blk == 10'(m + 1)) begin
          case (wb_adr[5:0])
            6'h00: begin
              rd = {23'b0, cfg_en_q[m], 2'b0, cfg_ch_q[m]};
              if (wr) begin
                cfg_ch_d[m] = wb_dat_i[5:0];
                cfg_en_d[m] = wb_dat_i[8];
              end
            end
            6'h08: begin rd = lower_q[m][31:0];  if (wr) lower_d[m][31:0]  = wb_dat_i; end
            6'h0C: begin rd = lower_q[m][63:32]; if (wr) lower_d[m][63:32] = wb_dat_i; end
            6'h10: begin rd = upper_q[m][31:0];  if (wr) upper_d[m][31:0]  = wb_dat_i; end
            6'h14: begin rd = upper_q[m][63:32]; if (wr) upper_d[m][63:32] = wb_dat_i; end
            6'h18: rd = ff_w[m][31:0];
            6'h1C: rd = ff_w[m][63:32];
            6'h20: rd = 32'(count_w[m]);
            default: rd = '0;
          endcase
        end
      end
    end
    dat_d  = (ack_d && !wb_we) ? rd : '0;
    fail_d = !clr_q && (|ff_vld);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_s1_q <= '0;
      t_s2_q <= '0;
      for (int m = 0; m < NUM_MON; m++) begin
        cfg_ch_q[m] <= 6'(m + 1);
        lower_q[m]  <= 64'h0000_0000_0066_0000;
        upper_q[m]  <= 64'h0000_0000_0068_0000;
      end
      cfg_en_q <= '0;
      gen_q    <= 1'b0;
      clr_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      fail_q   <= 1'b0;
    end else begin
      t_s1_q   <= t_s1_d;
      t_s2_q   <= t_s2_d;
      cfg_ch_q <= cfg_ch_d;
      cfg_en_q <= cfg_en_d;
      lower_q  <= lower_d;
      upper_q  <= upper_d;
      gen_q    <= gen_d;
      clr_q    <= clr_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      fail_q   <= fail_d;
    end
  end

  assign wb_ack   = ack_q;
  assign wb_dat_o = dat_q;
  assign fail_any = fail_q;
endmodule

// File: tb/tb_multi_interval_monitor.sv
// Directed bench: a default instance plus a CNT_WIDTH=4 instance fed the same stimulus.

module tb_multi_interval_monitor;
  logic         clk = 1'b0;
  logic         rst, tvalid, cyc, stb, we;
  logic [3:0]   tkeep;
  logic [23:0]  chan;
  logic [255:0] tt;
  logic [15:0]  adr;
  logic [31:0]  wdat;
  logic [31:0]  dat_a, dat_b;
  logic         rdy_a, rdy_b, ack_a, ack_b, fail_a, fail_b;
  int           passed = 0, total = 0;
  logic [31:0]  ra, rb;

  always #5 clk = ~clk;

  multi_interval_monitor dut (
    .clk(clk), .rst(rst), .s_axis_tvalid(tvalid), .s_axis_tready(rdy_a),
    .s_axis_tkeep(tkeep), .s_axis_channel(chan), .s_axis_tagtime(tt),
    .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr), .wb_dat_i(wdat),
    .wb_dat_o(dat_a), .wb_ack(ack_a), .fail_any(fail_a));

  multi_interval_monitor #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .s_axis_tvalid(tvalid), .s_axis_tready(rdy_b),
    .s_axis_tkeep(tkeep), .s_axis_channel(chan), .s_axis_tagtime(tt),
    .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr), .wb_dat_i(wdat),
    .wb_dat_o(dat_b), .wb_ack(ack_b), .fail_any(fail_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [15:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d;
    @(posedge clk); #1;
    chk("wr_ack", {31'b0, ack_a}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    idle(1);
  endtask

  task automatic wb_read(input logic [15:0] a, output logic [31:0] da, output logic [31:0] db);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    @(posedge clk); #1;
    da = ack_a ? dat_a : 32'hDEAD_BEEF;
    db = ack_b ? dat_b : 32'hDEAD_BEEF;
    cyc = 1'b0; stb = 1'b0;
    idle(1);
  endtask

  task automatic lane(input int i, input logic [5:0] c, input logic [63:0] t);
    chan[i*6 +: 6]  = c;
    tt[i*64 +: 64] = t;
  endtask

  task automatic send(input logic [3:0] keep);
    tvalid = 1'b1; tkeep = keep;
    @(posedge clk); #1;
    tvalid = 1'b0; tkeep = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    wb_read(a, ra, rb);
    chk(tag, ra, exp);
  endtask

  initial begin
    rst = 1'b1; tvalid = 1'b0; tkeep = '0; chan = '0; tt = '0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_tready", {31'b0, rdy_a}, 32'd1);
    chk("rst_ack", {31'b0, ack_a}, 32'd0);
    chk("rst_dat", dat_a, 32'd0);
    chk("rst_fail_any", {31'b0, fail_a}, 32'd0);
    rd_chk("id", 16'h0000, 32'd4);
    rd_chk("undecoded", 16'h0030, 32'd0);
    rd_chk("rst_cfg1", 16'h0080, 32'h0000_0002);
    wb_write(16'h0000, 32'h55);
    rd_chk("ro_ignored", 16'h0000, 32'd4);

    // 1) three single-lane beats on ch1, window [100,200]
    wb_write(16'h0004, 32'h2);
    wb_write(16'h0040, 32'h101);
    wb_write(16'h0048, 32'd100);
    wb_write(16'h0050, 32'd200);
    lane(0, 6'h01, 64'd1000); send(4'b0001);
    lane(0, 6'h01, 64'd1150); send(4'b0001);
    lane(0, 6'h01, 64'd1400); send(4'b0001);
    idle(8);
    rd_chk("t1_count", 16'h0060, 32'd1);
    rd_chk("t1_ff_lo", 16'h0058, 32'h0000_00FA);
    rd_chk("t1_ff_hi", 16'h005C, 32'h8000_0000);
    chk("t1_fail_any", {31'b0, fail_a}, 32'd1);

    // 2) one beat, four lanes: diffs 50 (fail), 100 (pass, inclusive), 250 (fail)
    wb_write(16'h0004, 32'h3);
    lane(0, 6'h01, 64'd0); lane(1, 6'h01, 64'd50);
    lane(2, 6'h01, 64'd150); lane(3, 6'h01, 64'd400);
    send(4'b1111);
    idle(8);
    rd_chk("t2_count", 16'h0060, 32'd2);
    rd_chk("t2_ff_lo", 16'h0058, 32'd50);
    rd_chk("t2_ff_hi", 16'h005C, 32'h8000_0000);

    // 3) m1 on falling ch1 (0x21) with window [10,20], interleaved with m0 on ch1
    wb_write(16'h0004, 32'h3);
    wb_write(16'h0080, 32'h121);
    wb_write(16'h0088, 32'd10);
    wb_write(16'h0090, 32'd20);
    lane(0, 6'h01, 64'd0); lane(1, 6'h21, 64'd5);
    lane(2, 6'h01, 64'd300); lane(3, 6'h21, 64'd20);
    send(4'b1111);
    lane(0, 6'h21, 64'd100); lane(1, 6'h01, 64'd450);
    send(4'b0011);
    idle(8);
    rd_chk("t3_m0_count", 16'h0060, 32'd1);
    rd_chk("t3_m0_ff", 16'h0058, 32'd300);
    rd_chk("t3_m1_count", 16'h00A0, 32'd1);
    rd_chk("t3_m1_ff", 16'h0098, 32'd80);

    // 4) 21 back-to-back ch1 tags 1000 apart -> 20 violations
    wb_write(16'h0004, 32'h3);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) lane(i, 6'h01, 64'((4 * k + i) * 1000));
      send(4'b1111);
    end
    lane(0, 6'h01, 64'd20000); send(4'b0001);
    idle(8);
    wb_read(16'h0060, ra, rb);
    chk("t4_count32", ra, 32'd20);
    chk("t4_count4_sat", rb, 32'd15);
    rd_chk("t4_ff", 16'h0058, 32'd1000);

    // 5) clear between 1000 and 5000: no diff; 5000 seeds, 5200 passes at upper, 5550 fails
    wb_write(16'h0004, 32'h3);
    lane(0, 6'h01, 64'd1000); send(4'b0001);
    idle(3);
    wb_write(16'h0004, 32'h3);
    lane(0, 6'h01, 64'd5000); send(4'b0001);
    idle(8);
    rd_chk("t5_count_cleared", 16'h0060, 32'd0);
    rd_chk("t5_ff_hi_cleared", 16'h005C, 32'd0);
    chk("t5_fail_any_cleared", {31'b0, fail_a}, 32'd0);
    lane(0, 6'h01, 64'd5200); send(4'b0001);
    lane(0, 6'h01, 64'd5550); send(4'b0001);
    idle(8);
    rd_chk("t5_count", 16'h0060, 32'd1);
    rd_chk("t5_ff_lo", 16'h0058, 32'd350);

    // 6) reset with a violating diff (450) sitting in S3
    lane(0, 6'h01, 64'd6000); send(4'b0001);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(8);
    wb_read(16'h0060, ra, rb);
    chk("t6_count", ra, 32'd0);
    chk("t6_count4", rb, 32'd0);
    rd_chk("t6_ff_hi", 16'h005C, 32'd0);
    chk("t6_fail_any", {31'b0, fail_a}, 32'd0);
    rd_chk("t6_cfg0", 16'h0040, 32'h0000_0001);
    rd_chk("t6_cfg1", 16'h0080, 32'h0000_0002);
    rd_chk("t6_lower", 16'h0048, 32'h0066_0000);
    rd_chk("t6_upper", 16'h0050, 32'h0068_0000);
    rd_chk("t6_gen", 16'h0004, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
